mycpu_load_wb: RTL and testbench

- MEM/WB pipeline register plus load-return path of the 5-stage MIPS core. It is the read-side counterpart of the MEM-stage store formatter.
- Captures MEM-stage results and waits for synchronous data-SRAM read data, which arrives one cycle after the read request.
- Holds that data across WB stalls.
- Performs LB/LBU/LH/LHU/LW/LWL/LWR extraction, sign/zero-extension and merge, then drives the regfile write port and debug trace.

---
 rtl/mycpu_load_wb_if.sv | 22 ++
 rtl/mycpu_load_wb.sv | 114 +++++++++++
 tb/tb_mycpu_load_wb.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/mycpu_load_wb_if.sv
// mycpu_load_wb_if: MEM-to-WB handshake and payload bundle.
interface mycpu_load_wb_if #(
    parameter int PC_W   = 32,
    parameter int REG_AW = 5
);
    logic              ms_to_ws_valid;
    logic              ws_allowin;
    logic [5:0]        ms_ls_mode;
    logic [31:0]       ms_alu_result;
    logic [31:0]       ms_rt_cont;
    logic              ms_rf_wen;
    logic [REG_AW-1:0] ms_dest;
    logic [PC_W-1:0]   ms_pc;
    modport master (
        output ms_to_ws_valid, ms_ls_mode, ms_alu_result, ms_rt_cont, ms_rf_wen, ms_dest, ms_pc,
        input  ws_allowin
    );
    modport slave (
        input  ms_to_ws_valid, ms_ls_mode, ms_alu_result, ms_rt_cont, ms_rf_wen, ms_dest, ms_pc,
        output ws_allowin
    );
endinterface

// File: rtl/mycpu_load_wb.sv
// mycpu_load_wb: MEM/WB pipeline register with load-data hold, extraction and regfile write.
module mycpu_load_wb #(
    parameter int PC_W   = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              resetn,
    mycpu_load_wb_if.slave    ms,
    input  logic              ws_flush,
    input  logic              wb_stall,
    input  logic [31:0]       data_sram_rdata,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_waddr,
    output logic [31:0]       rf_wdata,
    output logic [REG_AW-1:0] ws_dest,
    output logic [PC_W-1:0]   debug_wb_pc,
    output logic [3:0]        debug_wb_rf_wen,
    output logic [REG_AW-1:0] debug_wb_rf_wnum,
    output logic [31:0]       debug_wb_rf_wdata
);
    logic              ws_valid;
    logic              hold_vld;
    logic [31:0]       rdata_hold;
    logic              is_load;
    logic [2:0]        size;
    logic              zext;
    logic [31:0]       alu_result;
    logic [31:0]       rt_cont;
    logic              rf_wen;
    logic [REG_AW-1:0] dest;
    logic [PC_W-1:0]   pc;
    logic              ws_ready_go;
    logic              ws_allowin;
    logic [1:0]        a;
    logic [31:0]       d;
    logic [7:0]        byte_sel;
    logic [15:0]       half_sel;
    logic [31:0]       lwl_data;
    logic [31:0]       lwr_data;
    logic [31:0]       load_data;

    assign ws_ready_go   = !wb_stall;
    assign ws_allowin    = !ws_valid | ws_ready_go;
    assign ms.ws_allowin = ws_allowin;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ws_valid   <= 1'b0;
            hold_vld   <= 1'b0;
            rdata_hold <= '0;
            is_load    <= 1'b0;
            size       <= '0;
            zext       <= 1'b0;
            alu_result <= '0;
            rt_cont    <= '0;
            rf_wen     <= 1'b0;
            dest       <= '0;
            pc         <= '0;
        end else begin
            if (ws_allowin)
                ws_valid <= ms.ms_to_ws_valid & !ws_flush;
            else if (ws_flush)
                ws_valid <= 1'b0;
            if (ws_allowin && ms.ms_to_ws_valid) begin
                is_load    <= ms.ms_ls_mode[5];
                size       <= ms.ms_ls_mode[3:1];
                zext       <= ms.ms_ls_mode[0];
                alu_result <= ms.ms_alu_result;
                rt_cont    <= ms.ms_rt_cont;
                rf_wen     <= ms.ms_rf_wen;
                dest       <= ms.ms_dest;
                pc         <= ms.ms_pc;
            end
            // SRAM data is only valid in the entry's first cycle; freeze it if WB stalls then
            if (ws_allowin || ws_flush)
                hold_vld <= 1'b0;
            else if (ws_valid && is_load && !hold_vld) begin
                hold_vld   <= 1'b1;
                rdata_hold <= data_sram_rdata;
            end
        end
    end

    assign a        = alu_result[1:0];
    assign d        = hold_vld ? rdata_hold : data_sram_rdata;
    assign byte_sel = a == 2'd0 ? d[7:0] : a == 2'd1 ? d[15:8] : a == 2'd2 ? d[23:16] : d[31:24];
    assign half_sel = a[1] ? d[31:16] : d[15:0];
    assign lwl_data = a == 2'd0 ? {d[7:0], rt_cont[23:0]} :
                      a == 2'd1 ? {d[15:0], rt_cont[15:0]} :
                      a == 2'd2 ? {d[23:0], rt_cont[7:0]} : d;
    assign lwr_data = a == 2'd0 ? d :
                      a == 2'd1 ? {rt_cont[31:24], d[31:8]} :
                      a == 2'd2 ? {rt_cont[31:16], d[31:16]} : {rt_cont[31:8], d[31:24]};

    always_comb begin
        load_data = d;
        case (size)
            3'b000:  load_data = {{24{byte_sel[7] & !zext}}, byte_sel};
            3'b001:  load_data = {{16{half_sel[15] & !zext}}, half_sel};
            3'b011:  load_data = lwl_data;
            3'b100:  load_data = lwr_data;
            default: load_data = d;
        endcase
    end

    assign rf_we             = ws_valid & rf_wen & ws_ready_go & !ws_flush;
    assign rf_waddr          = dest;
    assign rf_wdata          = is_load ? load_data : alu_result;
    assign ws_dest           = (ws_valid & rf_wen) ? dest : '0;
    assign debug_wb_pc       = pc;
    assign debug_wb_rf_wen   = {4{rf_we}};
    assign debug_wb_rf_wnum  = rf_waddr;
    assign debug_wb_rf_wdata = rf_wdata;
endmodule

// File: tb/tb_mycpu_load_wb.sv
// tb_mycpu_load_wb: directed plus random checks of mycpu_load_wb against an arithmetic load model.
module tb_mycpu_load_wb;
    logic        clk = 1'b0;
    logic        resetn = 1'b1;
    logic        ws_flush = 1'b0;
    logic        wb_stall = 1'b0;
    logic [31:0] rdata = '0;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [4:0]  ws_dest;
    logic [31:0] debug_wb_pc;
    logic [3:0]  debug_wen;
    logic [4:0]  debug_wnum;
    logic [31:0] debug_wdata;

    int n_chk = 0;
    int n_fail = 0;

    logic        m_valid, m_first, m_wen;
    logic [5:0]  m_mode;
    logic [31:0] m_addr, m_rt, m_data, m_pc;
    logic [4:0]  m_dest;
    logic        last_we, last_allow;
    logic [31:0] last_wdata;
    logic [4:0]  last_dest;

    mycpu_load_wb_if #(.PC_W(32), .REG_AW(5)) ms ();

    mycpu_load_wb #(.PC_W(32), .REG_AW(5)) dut (
        .clk               (clk),
        .resetn            (resetn),
        .ms                (ms),
        .ws_flush          (ws_flush),
        .wb_stall          (wb_stall),
        .data_sram_rdata   (rdata),
        .rf_we             (rf_we),
        .rf_waddr          (rf_waddr),
        .rf_wdata          (rf_wdata),
        .ws_dest           (ws_dest),
        .debug_wb_pc       (debug_wb_pc),
        .debug_wb_rf_wen   (debug_wen),
        .debug_wb_rf_wnum  (debug_wnum),
        .debug_wb_rf_wdata (debug_wdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] fmt(logic [5:0] mode, logic [31:0] addr, logic [31:0] rt, logic [31:0] d);
        int sh;
        logic [31:0] v;
        logic [63:0] msk;
        sh = 8 * int'(addr[1:0]);
        if (!mode[5]) return addr;
        case (mode[3:1])
            3'd0: begin
                v = (d >> sh) & 32'hff;
                return (mode[0] || !v[7]) ? v : (v | 32'hffff_ff00);
            end
            3'd1: begin
                v = (d >> ((sh / 16) * 16)) & 32'hffff;
                return (mode[0] || !v[15]) ? v : (v | 32'hffff_0000);
            end
            3'd3: begin
                msk = (64'd1 << (24 - sh)) - 64'd1;
                return 32'(({32'd0, d} << (24 - sh)) | ({32'd0, rt} & msk));
            end
            3'd4: return (d >> sh) | (rt & ~(32'hffff_ffff >> sh));
            default: return d;
        endcase
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_valid = 0; m_first = 1; m_wen = 0; m_mode = '0;
        m_addr = '0; m_rt = '0; m_data = '0; m_pc = '0; m_dest = '0;
    endtask

    task automatic tick();
        logic ex_allow, ex_we;
        logic [31:0] ex_wd;
        logic [4:0] ex_dest;
        #3;
        ex_allow = !m_valid || !wb_stall;
        ex_we    = m_valid && m_wen && !wb_stall && !ws_flush;
        ex_wd    = fmt(m_mode, m_addr, m_rt, m_first ? rdata : m_data);
        ex_dest  = (m_valid && m_wen) ? m_dest : 5'd0;
        chk("allowin", 32'(ms.ws_allowin), 32'(ex_allow));
        chk("rf_we", 32'(rf_we), 32'(ex_we));
        chk("debug_wen", 32'(debug_wen), {28'd0, {4{ex_we}}});
        chk("ws_dest", 32'(ws_dest), 32'(ex_dest));
        chk("rf_waddr", 32'(rf_waddr), 32'(m_dest));
        chk("debug_wnum", 32'(debug_wnum), 32'(m_dest));
        chk("debug_pc", debug_wb_pc, m_pc);
        if (m_valid) begin
            chk("rf_wdata", rf_wdata, ex_wd);
            chk("debug_wdata", debug_wdata, ex_wd);
        end
        last_we = rf_we; last_wdata = rf_wdata; last_allow = ms.ws_allowin; last_dest = ws_dest;
        @(posedge clk);
        #1;
        if (m_first) begin m_data = rdata; m_first = 0; end
        if (ex_allow) begin
            if (ms.ms_to_ws_valid) begin
                m_mode = ms.ms_ls_mode; m_addr = ms.ms_alu_result; m_rt = ms.ms_rt_cont;
                m_wen = ms.ms_rf_wen; m_dest = ms.ms_dest; m_pc = ms.ms_pc;
            end
            m_valid = ms.ms_to_ws_valid && !ws_flush;
            m_first = 1;
        end else if (ws_flush) m_valid = 0;
    endtask

    task automatic reset_pulse();
        resetn = 1'b0;
        #1;
        chk("rst_rf_we", 32'(rf_we), 32'd0);
        chk("rst_rf_waddr", 32'(rf_waddr), 32'd0);
        chk("rst_rf_wdata", rf_wdata, 32'd0);
        chk("rst_ws_dest", 32'(ws_dest), 32'd0);
        chk("rst_debug_pc", debug_wb_pc, 32'd0);
        chk("rst_allowin", 32'(ms.ws_allowin), 32'd1);
        model_reset();
        @(posedge clk);
        #1;
        resetn = 1'b1;
    endtask

    task automatic put(logic [5:0] mode, logic [31:0] addr, logic [31:0] rt, logic wen, logic [4:0] dst, logic [31:0] pc);
        ms.ms_to_ws_valid = 1'b1; ms.ms_ls_mode = mode; ms.ms_alu_result = addr;
        ms.ms_rt_cont = rt; ms.ms_rf_wen = wen; ms.ms_dest = dst; ms.ms_pc = pc;
    endtask

    task automatic idle();
        ms.ms_to_ws_valid = 1'b0;
    endtask

    logic [5:0] modes [12];

    initial begin
        modes = '{6'b000000, 6'b010100, 6'b100000, 6'b100001, 6'b100010, 6'b100011,
                  6'b100100, 6'b100110, 6'b101000, 6'b101010, 6'b101100, 6'b101110};
        put(6'b000000, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        idle();
        model_reset();
        #2;
        reset_pulse();
        // LB / LBU on byte 1
        rdata = 32'h1234_80FF;
        put(6'b100000, 32'h0000_1001, 32'd0, 1'b1, 5'd5, 32'hBFC0_0000); tick();
        put(6'b100001, 32'h0000_1001, 32'd0, 1'b1, 5'd6, 32'hBFC0_0004); tick();
        chk("t1_lb_we", 32'(last_we), 32'd1);
        chk("t1_lb", last_wdata, 32'hFFFF_FF80);
        idle(); tick();
        chk("t1_lbu", last_wdata, 32'h0000_0080);
        tick();
        chk("t1_single_write", 32'(last_we), 32'd0);
        // LWL / LWR merge
        rdata = 32'h1122_3344;
        put(6'b100110, 32'h0000_2002, 32'hAABB_CCDD, 1'b1, 5'd7, 32'hBFC0_0010); tick();
        put(6'b101000, 32'h0000_2001, 32'hAABB_CCDD, 1'b1, 5'd8, 32'hBFC0_0014); tick();
        chk("t2_lwl", last_wdata, 32'h2233_44DD);
        idle(); tick();
        chk("t2_lwr", last_wdata, 32'hAA11_2233);
        // LW held across a 3-cycle stall while SRAM data changes
        rdata = 32'hCAFE_F00D;
        put(6'b100100, 32'h0000_0100, 32'd0, 1'b1, 5'd9, 32'hBFC0_0020); tick();
        idle(); wb_stall = 1'b1; tick();
        chk("t3_allow_stall", 32'(last_allow), 32'd0);
        rdata = 32'hDEAD_BEEF; tick(); tick();
        chk("t3_no_we_stall", 32'(last_we), 32'd0);
        wb_stall = 1'b0; tick();
        chk("t3_we", 32'(last_we), 32'd1);
        chk("t3_held", last_wdata, 32'hCAFE_F00D);
        // flush kills a valid LW
        put(6'b100100, 32'h0000_0200, 32'd0, 1'b1, 5'd10, 32'hBFC0_0030); tick();
        idle(); ws_flush = 1'b1; tick();
        chk("t4_flush_we", 32'(last_we), 32'd0);
        ws_flush = 1'b0; tick();
        chk("t4_dest", 32'(last_dest), 32'd0);
        // ADDU, LH, SW back-to-back
        put(6'b000000, 32'h1234_5678, 32'd0, 1'b1, 5'd3, 32'hBFC0_0040); tick();
        rdata = 32'h8001_0000;
        put(6'b100010, 32'h0000_3002, 32'd0, 1'b1, 5'd4, 32'hBFC0_0044); tick();
        chk("t5_addu", last_wdata, 32'h1234_5678);
        put(6'b010100, 32'h0000_3004, 32'h5555_5555, 1'b0, 5'd0, 32'hBFC0_0048); tick();
        chk("t5_lh_we", 32'(last_we), 32'd1);
        chk("t5_lh", last_wdata, 32'hFFFF_8001);
        idle(); tick();
        chk("t5_sw", 32'(last_we), 32'd0);
        // reset in the middle of a stall
        put(6'b100100, 32'h0000_0300, 32'd0, 1'b1, 5'd11, 32'hBFC0_0050); tick();
        idle(); wb_stall = 1'b1; tick();
        reset_pulse();
        wb_stall = 1'b0; tick();
        chk("t6_no_write", 32'(last_we), 32'd0);
        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic [5:0] md;
            logic [31:0] ad;
            md = modes[$urandom_range(0, 11)];
            ad = $urandom;
            if (md[5] && md[3:1] == 3'b001) ad[0] = 1'b0;
            if ($urandom_range(0, 9) < 7)
                put(md, ad, $urandom, !md[4], 5'($urandom), $urandom);
            else
                idle();
            wb_stall = ($urandom_range(0, 9) < 3);
            ws_flush = ($urandom_range(0, 19) == 0);
            rdata = $urandom;
            tick();
        end
        wb_stall = 1'b0; ws_flush = 1'b0; idle();
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
